mean3x3_window: RTL and testbench
=================================

# mean3x3_window

Consumes the raster pixel stream together with the two delayed rows produced by the line buffers, assembles a 3×3 window, and outputs the window mean. It sits directly downstream of the two cascaded line-buffer stages in the mean-filter datapath and feeds the output formatter. Only windows that fall fully inside the frame produce output; there is no backpressure.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- IMG_WIDTH, 640, pixels per row (≥3)
- IMG_HEIGHT, 480, rows per frame (≥3)
- RECIP, 7282, fixed-point 2^16/9 multiplier
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  one pixel per asserted cycle on all three data inputs
- in_sof  in  1  qualifies with in_valid; marks pixel (0,0) of a frame
- data_in  in  DATA_WIDTH  current-row pixel
- line1_in  in  DATA_WIDTH  same column, one row above (first line buffer output)
- line2_in  in  DATA_WIDTH  same column, two rows above (second line buffer output)
- out_valid  out  1  out_data valid this cycle
- out_data  out  DATA_WIDTH  window mean, centre at (row-1, col-1)
- out_sof  out  1  first output of a frame, with out_valid
- out_eol  out  1  last output of a row, with out_valid

## Operation
- Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) advance on in_valid; col wraps to 0 and increments row; row wraps to 0 after last pixel.
- in_sof with in_valid forces the current pixel to (0,0) regardless of counter state; counters continue from (0,1).
- Window: three 3-deep column shift registers (rows line2/line1/data) shift on in_valid only; values persist across gaps.
- Window complete when the accepted pixel has row≥2 and col≥2; else no output for that pixel (output count per frame = (IMG_WIDTH-2)·(IMG_HEIGHT-2)).
- Shift registers are not cleared at row wrap; windows with col<2 are discarded, so stale columns never reach output.
- Stage 1: sum of 9 pixels, width DATA_WIDTH+4, unsigned, exact.
- Stage 2: out_data = (sum·RECIP + ROUND) >> 16, ROUND per Configuration; result clamped to 2^DATA_WIDTH-1.
- out_sof asserted for window completed by pixel (2,2); out_eol for window completed by col = IMG_WIDTH-1.
- Inputs line1_in/line2_in are trusted column-aligned; no check for line buffer fill state (row<2 windows are discarded).

## Timing
- Reset: out_valid=0, out_data=0, out_sof=0, out_eol=0, col=0, row=0, pipeline valid bits cleared; window registers need not be cleared.
- Latency: window-completing in_valid at cycle N → out_valid at N+2 (register after window, register after sum, register after multiply counted as: window capture N, sum N+1, output N+2).
- Pipeline advances every cycle; in_valid gaps produce matching out_valid gaps; full throughput 1 pixel/cycle.
- out_sof/out_eol/out_data held 0 whenever out_valid=0.
- Reset mid-frame: in-flight outputs dropped, next in_valid treated as (0,0) unless in_sof indicates otherwise (same result).
- in_sof mid-frame: partial frame abandoned; outputs already in pipeline still emerge.

## Configuration
- MEAN_ROUND_EN defined: ROUND = 2^15 (round to nearest, ties up).
- Not defined: ROUND = 0 (truncation). No other behaviour changes.

## Test plan
- Constant frame 5×4, all pixels 100 on all inputs → exactly 6 outputs, all 100; first has out_sof, 3rd and 6th have out_eol.
- Max value: all inputs 255 → out_data 255 both with and without MEAN_ROUND_EN (no overflow).
- Rounding: window sum 13 (one pixel 5, one 8, rest 0) → 1 without MEAN_ROUND_EN, 1 with; sum 14 → 1 without, 2 with.
- Latency/gaps: IMG_WIDTH=3, IMG_HEIGHT=3, in_valid every other cycle → single output exactly 2 cycles after 9th in_valid, with out_sof and out_eol both set.
- Ramp image pixel=row·IMG_WIDTH+col (mod 256) through line-buffer model → each output matches reference mean of its 3×3 neighbourhood; count = (W-2)(H-2).
- rst_n low for 1 cycle mid-frame, then new frame with in_sof → no outputs from old frame after reset cycle; new frame output sequence identical to clean-start run.

Source files
------------

// File: rtl/mean3x3_window.sv
// 3x3 window assembly and mean for the mean-filter datapath: window capture, 9-pixel sum, reciprocal multiply.
// Define MEAN_ROUND_EN to round the mean to nearest (ties up); otherwise the mean is truncated.
module mean3x3_window #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int RECIP      = 7282
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] line1_in,
  input  logic [DATA_WIDTH-1:0] line2_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eol
);

  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ROW_W  = $clog2(IMG_HEIGHT);
  localparam int SUM_W  = DATA_WIDTH + 4;
  localparam int PROD_W = SUM_W + 18;

  localparam logic [COL_W-1:0]      COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [DATA_WIDTH-1:0] PIX_MAX  = {DATA_WIDTH{1'b1}};
  localparam logic [PROD_W-1:0]     QMAX     = {{(PROD_W-DATA_WIDTH){1'b0}}, PIX_MAX};
  localparam logic [PROD_W-1:0]     RECIP_V  = PROD_W'(RECIP);
`ifdef MEAN_ROUND_EN
  localparam logic [PROD_W-1:0]     ROUND_V  = PROD_W'(32'd32768);
`else
  localparam logic [PROD_W-1:0]     ROUND_V  = {PROD_W{1'b0}};
`endif

  logic [COL_W-1:0]      col_r, cur_col_s, nxt_col_s;
  logic [ROW_W-1:0]      row_r, cur_row_s, nxt_row_s;
  logic [DATA_WIDTH-1:0] w0_r [3];
  logic [DATA_WIDTH-1:0] w1_r [3];
  logic [DATA_WIDTH-1:0] w2_r [3];
  logic                  win_cmp_s;
  logic                  win_vld_r, win_sof_r, win_eol_r;
  logic [SUM_W-1:0]      sum_s, sum_r;
  logic                  sum_vld_r, sum_sof_r, sum_eol_r;
  logic [PROD_W-1:0]     prod_s, quo_s;
  logic [DATA_WIDTH-1:0] mean_s;

  // Position of the pixel on the inputs (in_sof overrides the counters) and the position after it.
  always_comb begin
    cur_col_s = col_r;
    cur_row_s = row_r;
    nxt_col_s = col_r;
    nxt_row_s = row_r;
    if (in_sof) begin
      cur_col_s = {COL_W{1'b0}};
      cur_row_s = {ROW_W{1'b0}};
    end else begin
      cur_col_s = col_r;
      cur_row_s = row_r;
    end
    if (cur_col_s == COL_LAST) begin
      nxt_col_s = {COL_W{1'b0}};
      if (cur_row_s == ROW_LAST) begin
        nxt_row_s = {ROW_W{1'b0}};
      end else begin
        nxt_row_s = cur_row_s + ROW_W'(1);
      end
    end else begin
      nxt_col_s = cur_col_s + COL_W'(1);
      nxt_row_s = cur_row_s;
    end
    win_cmp_s = in_valid && (cur_row_s >= ROW_W'(2)) && (cur_col_s >= COL_W'(2));
  end

  // Raster position counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_r <= {COL_W{1'b0}};
      row_r <= {ROW_W{1'b0}};
    end else if (in_valid) begin
      col_r <= nxt_col_s;
      row_r <= nxt_row_s;
    end
  end

  // Window column shift registers; index 2 holds the newest column, contents persist across gaps.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      w0_r[0] <= w0_r[1];  w0_r[1] <= w0_r[2];  w0_r[2] <= data_in;
      w1_r[0] <= w1_r[1];  w1_r[1] <= w1_r[2];  w1_r[2] <= line1_in;
      w2_r[0] <= w2_r[1];  w2_r[1] <= w2_r[2];  w2_r[2] <= line2_in;
    end
  end

  // Window-stage qualifiers; partial windows at row/column starts never become valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_vld_r <= 1'b0;
      win_sof_r <= 1'b0;
      win_eol_r <= 1'b0;
    end else begin
      win_vld_r <= win_cmp_s;
      win_sof_r <= win_cmp_s && (cur_row_s == ROW_W'(2)) && (cur_col_s == COL_W'(2));
      win_eol_r <= win_cmp_s && (cur_col_s == COL_LAST);
    end
  end

  // Exact 9-pixel sum, then fixed-point divide by 9 with saturation.
  always_comb begin
    sum_s = SUM_W'(w0_r[0]) + SUM_W'(w0_r[1]) + SUM_W'(w0_r[2])
          + SUM_W'(w1_r[0]) + SUM_W'(w1_r[1]) + SUM_W'(w1_r[2])
          + SUM_W'(w2_r[0]) + SUM_W'(w2_r[1]) + SUM_W'(w2_r[2]);
    prod_s = PROD_W'(sum_r) * RECIP_V + ROUND_V;
    quo_s  = prod_s >> 16;
    if (quo_s > QMAX) begin
      mean_s = PIX_MAX;
    end else begin
      mean_s = quo_s[DATA_WIDTH-1:0];
    end
  end

  // Sum stage register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_r     <= {SUM_W{1'b0}};
      sum_vld_r <= 1'b0;
      sum_sof_r <= 1'b0;
      sum_eol_r <= 1'b0;
    end else begin
      sum_r     <= sum_s;
      sum_vld_r <= win_vld_r;
      sum_sof_r <= win_sof_r;
      sum_eol_r <= win_eol_r;
    end
  end

  // Output register; data and flags are forced to zero whenever no window is emitted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {DATA_WIDTH{1'b0}};
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else begin
      out_valid <= sum_vld_r;
      out_data  <= sum_vld_r ? mean_s : {DATA_WIDTH{1'b0}};
      out_sof   <= sum_vld_r && sum_sof_r;
      out_eol   <= sum_vld_r && sum_eol_r;
    end
  end

endmodule

// File: tb/tb_mean3x3_window.sv
// Randomized/directed bench for mean3x3_window: a 5x4 and a 3x3 instance share one input stream and are
// checked every cycle against a frame-level reference model (window of the last three accepted columns).
module tb_mean3x3_window;

  localparam int WA = 5, HA = 4, WB = 3, HB = 3;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
  logic [7:0] data_in = 8'd0, line1_in = 8'd0, line2_in = 8'd0;
  logic ova, osa, oea, ovb, osb, oeb;
  logic [7:0] oda, odb;

  always #5 clk = ~clk;

  mean3x3_window #(.DATA_WIDTH(8), .IMG_WIDTH(WA), .IMG_HEIGHT(HA), .RECIP(7282)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .data_in(data_in), .line1_in(line1_in), .line2_in(line2_in),
    .out_valid(ova), .out_data(oda), .out_sof(osa), .out_eol(oea));

  mean3x3_window #(.DATA_WIDTH(8), .IMG_WIDTH(WB), .IMG_HEIGHT(HB), .RECIP(7282)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .data_in(data_in), .line1_in(line1_in), .line2_in(line2_in),
    .out_valid(ovb), .out_data(odb), .out_sof(osb), .out_eol(oeb));

  int total = 0, bad = 0, cyc = 0, out_cyc_b = 0, last_pix_cyc = 0;
  int cnt [2];
  int mcol [2];
  int mrow [2];
  int hs [2][3];
  logic [10:0] p1 [2];
  logic [10:0] p2 [2];
  int img [4][5];
  logic [10:0] cap[$];
  logic [10:0] ref_seq[$];
  bit cap_en = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: window = last three accepted columns; output record {valid,sof,eol,mean}.
  task automatic model(input int d, input int w, input int ht, input logic v, input logic s,
                       input int px, input int l1, input int l2, output logic [10:0] r);
    int cc, rr, sm, m;
    r = 11'd0;
    if (!v) return;
    cc = s ? 0 : mcol[d];
    rr = s ? 0 : mrow[d];
    hs[d][0] = hs[d][1];
    hs[d][1] = hs[d][2];
    hs[d][2] = px + l1 + l2;
    if (rr >= 2 && cc >= 2) begin
      sm = hs[d][0] + hs[d][1] + hs[d][2];
`ifdef MEAN_ROUND_EN
      m = (sm + 4) / 9;
`else
      m = sm / 9;
`endif
      if (m > 255) m = 255;
      r = {1'b1, (rr == 2 && cc == 2), (cc == w - 1), 8'(m)};
    end
    cc++;
    if (cc == w) begin
      cc = 0;
      rr = (rr + 1 == ht) ? 0 : rr + 1;
    end
    mcol[d] = cc;
    mrow[d] = rr;
  endtask

  task automatic tick(input logic v, input logic s, input int px, input int l1, input int l2);
    logic [10:0] ra, rb, oa, ob;
    in_valid = v; in_sof = s;
    data_in = 8'(px); line1_in = 8'(l1); line2_in = 8'(l2);
    model(0, WA, HA, v, s, px, l1, l2, ra);
    model(1, WB, HB, v, s, px, l1, l2, rb);
    @(posedge clk);
    #1;
    cyc++;
    oa = {ova, osa, oea, oda};
    ob = {ovb, osb, oeb, odb};
    chk("out_a", int'(oa), int'(p2[0]));
    chk("out_b", int'(ob), int'(p2[1]));
    p2[0] = p1[0]; p1[0] = ra;
    p2[1] = p1[1]; p1[1] = rb;
    if (ova) begin
      cnt[0]++;
      if (cap_en) cap.push_back(oa);
    end
    if (ovb) begin
      cnt[1]++;
      out_cyc_b = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      tick(1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    chk("rst_a", int'({ova, osa, oea, oda}), 0);
    chk("rst_b", int'({ovb, osb, oeb, odb}), 0);
    for (int d = 0; d < 2; d++) begin
      p1[d] = 11'd0; p2[d] = 11'd0; mcol[d] = 0; mrow[d] = 0;
    end
    rst_n = 1'b1;
  endtask

  // Drives a frame through an ideal line-buffer model; rows above the frame carry junk.
  task automatic drive_frame(input int w, input int ht, input int gmode, input int npix);
    int n = 0;
    for (int r = 0; r < ht; r++) begin
      for (int c = 0; c < w; c++) begin
        if (n < npix) begin
          tick(1'b1, (r == 0 && c == 0), img[r][c],
               (r >= 1) ? img[r-1][c] : int'($urandom_range(0, 255)),
               (r >= 2) ? img[r-2][c] : int'($urandom_range(0, 255)));
          last_pix_cyc = cyc;
          n++;
          if (gmode == 1) idle(1);
          else if (gmode == 2) idle($urandom_range(0, 2));
        end
      end
    end
  endtask

  task automatic fill(input int v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        img[r][c] = v;
  endtask

  initial begin
    logic [10:0] e;
    cnt[0] = 0; cnt[1] = 0;
    for (int d = 0; d < 2; d++) for (int k = 0; k < 3; k++) hs[d][k] = 0;
    do_reset();
    do_reset();

    // Constant frame of 100.
    fill(100); cnt[0] = 0; cap.delete(); cap_en = 1'b1;
    drive_frame(WA, HA, 0, 20);
    idle(3);
    chk("const_cnt", cnt[0], 6);
    e = cap[0]; chk("const_first", int'(e), int'({1'b1, 1'b1, 1'b0, 8'd100}));
    e = cap[2]; chk("const_eol3", int'(e), int'({1'b1, 1'b0, 1'b1, 8'd100}));
    e = cap[5]; chk("const_eol6", int'(e), int'({1'b1, 1'b0, 1'b1, 8'd100}));

    // Saturated frame.
    fill(255); cap.delete();
    drive_frame(WA, HA, 2, 20);
    idle(3);
    e = cap[0]; chk("max_first", int'(e[7:0]), 255);

    // Rounding: window sum 13, then 14.
    fill(0); img[0][0] = 5; img[1][1] = 8; cap.delete();
    drive_frame(WA, HA, 0, 20);
    idle(3);
    e = cap[0]; chk("round13", int'(e[7:0]), 1);
    img[0][0] = 6; cap.delete();
    drive_frame(WA, HA, 0, 20);
    idle(3);
    e = cap[0];
`ifdef MEAN_ROUND_EN
    chk("round14", int'(e[7:0]), 2);
`else
    chk("round14", int'(e[7:0]), 1);
`endif

    // Latency with gaps on the 3x3 instance.
    for (int r = 0; r < 4; r++) for (int c = 0; c < 5; c++) img[r][c] = $urandom_range(0, 255);
    cnt[1] = 0; out_cyc_b = 0;
    drive_frame(WB, HB, 1, 9);
    idle(4);
    chk("lat_cnt", cnt[1], 1);
    chk("lat_cyc", out_cyc_b - last_pix_cyc, 2);

    // Ramp image, then random images, with random gaps.
    for (int r = 0; r < 4; r++) for (int c = 0; c < 5; c++) img[r][c] = (r * WA + c) % 256;
    cnt[0] = 0;
    drive_frame(WA, HA, 2, 20);
    idle(3);
    chk("ramp_cnt", cnt[0], 6);
    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < 4; r++) for (int c = 0; c < 5; c++) img[r][c] = $urandom_range(0, 255);
      drive_frame(WA, HA, 2, 20);
    end
    idle(3);

    // Reset mid-frame: restarted frame must reproduce a clean run.
    for (int r = 0; r < 4; r++) for (int c = 0; c < 5; c++) img[r][c] = (r * 37 + c * 11) % 256;
    cap.delete();
    drive_frame(WA, HA, 0, 20);
    idle(3);
    ref_seq = cap;
    drive_frame(WA, HA, 0, 14);
    do_reset();
    cap.delete();
    drive_frame(WA, HA, 0, 20);
    idle(3);
    chk("rst_seq_len", cap.size(), ref_seq.size());
    for (int i = 0; i < cap.size() && i < ref_seq.size(); i++)
      chk("rst_seq", int'(cap[i]), int'(ref_seq[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
